// File: rtl/cacheline_arbiter.sv
// Arbitrates one shared cache-line port to L2 between an I-side reader and a
// D-side reader/writer. The D-side has priority, but the I-side can only be
// passed over a bounded number of times while it waits.
module cacheline_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic [255:0] i_rdata,
    output logic         i_resp,

    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,

    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output logic [255:0] burst_o,
    input  logic [255:0] burst_i,
    input  logic         resp_i,

    output logic [31:0]  i_grant_count,
    output logic [31:0]  d_grant_count
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          d_req;
    logic          pick_i;

    assign d_req  = d_read | d_write;
    // The I-side wins when it is alone, or when it has been passed over LIMIT times.
    assign pick_i = i_read && (!d_req || (starve_cnt == LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values; the async reset branch returns them to a known state.
        if (!rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            i_grant_count <= '0;
            d_grant_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        state      <= SERVE_I;
                        starve_cnt <= '0;
                    end else if (d_req) begin
                        state <= SERVE_D;
                        if (i_read && (starve_cnt != LIMIT)) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                SERVE_I: begin
                    if (resp_i) begin
                        state         <= IDLE;
                        i_grant_count <= i_grant_count + 32'd1;
                    end
                end
                SERVE_D: begin
                    if (resp_i) begin
                        state         <= IDLE;
                        d_grant_count <= d_grant_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream command and upstream response follow the owner combinationally;
    // reset forces IDLE, so everything here is quiet while rst is low.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        address_o = '0;
        read_o    = 1'b0;
        write_o   = 1'b0;
        burst_o   = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state)
            SERVE_I: begin
                address_o = i_address;
                read_o    = 1'b1;
                i_resp    = resp_i;
            end
            SERVE_D: begin
                address_o = d_address;
                burst_o   = d_wdata;
                write_o   = d_write;
                read_o    = d_read & ~d_write;
                d_resp    = resp_i;
            end
            default: ;
        endcase
    end

    assign i_rdata = burst_i;
    assign d_rdata = burst_i;

endmodule

// File: doc/cacheline_arbiter.md
CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: the maximum number of consecutive D-side grants allowed while the I-side is waiting.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 Ports for the I-side upstream (read-only requester):
- i_read, input, 1 bit
- i_address, input, 32 bits
- i_rdata, output, 256 bits
- i_resp, output, 1 bit
REQ-005 Ports for the D-side upstream requester:
- d_read, input, 1 bit
- d_write, input, 1 bit
- d_address, input, 32 bits
- d_wdata, input, 256 bits
- d_rdata, output, 256 bits
- d_resp, output, 1 bit
REQ-006 Ports for the shared downstream line port to L2:
- address_o, output, 32 bits
- read_o, output, 1 bit
- write_o, output, 1 bit
- burst_o, output, 256 bits
- burst_i, input, 256 bits
- resp_i, input, 1 bit
REQ-007 Performance-counter outputs, each 32 bits:
- i_grant_count: completed I-side transactions.
- d_grant_count: completed D-side transactions.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D; the state is registered.
REQ-009 In IDLE, read_o and write_o SHALL be 0, and i_resp and d_resp SHALL be 0.
REQ-010 Grant decision in IDLE at each rising edge:
- Only the I-side requesting (i_read) -> SERVE_I.
- Only the D-side requesting (d_read|d_write) -> SERVE_D.
- Both requesting -> SERVE_D, unless starve_cnt == STARVE_LIMIT, in which case SERVE_I.
- Neither requesting -> stay in IDLE.
REQ-011 starve_cnt (clog2(STARVE_LIMIT+1) bits) update rules:
- Increments on each IDLE->SERVE_D transition taken while i_read=1.
- Clears on each IDLE->SERVE_I transition.
- Saturates at STARVE_LIMIT.
REQ-012 In SERVE_I the downstream port SHALL be driven as follows:
- address_o = i_address.
- read_o = 1.
- write_o = 0.
- burst_o = 0.
REQ-013 In SERVE_D the downstream port SHALL be driven as follows:
- address_o = d_address.
- burst_o = d_wdata.
- write_o = d_write.
- read_o = d_read & ~d_write; a write takes precedence if both are asserted.
REQ-014 Downstream outputs SHALL be combinational from state and the owner's inputs; the owner holds its inputs stable until its resp.
REQ-015 Response routing SHALL be combinational:
- In SERVE_I, i_resp = resp_i.
- In SERVE_D, d_resp = resp_i.
- The non-owner's resp SHALL be 0.
REQ-016 Read data SHALL be passed through as i_rdata = burst_i and d_rdata = burst_i in all states; it is valid only with the corresponding resp.
REQ-017 On resp_i=1 in SERVE_I or SERVE_D, the next state SHALL be IDLE, and the matching grant counter SHALL increment (wrapping at 2^32).
REQ-018 Ownership SHALL never change before resp_i; new requests arriving mid-transaction wait.
REQ-019 resp_i received while in IDLE SHALL be ignored: no state change, no upstream resp.
REQ-020 Latency: a request sampled at edge k drives downstream from cycle k+1; each transaction is followed by at least one IDLE cycle.
REQ-021 If a requester drops its request mid-transaction (protocol violation), the arbiter SHALL remain in the SERVE state until resp_i.

Reset
REQ-022 While rst=0, asynchronously:
- state = IDLE.
- starve_cnt = 0.
- i_grant_count = 0.
- d_grant_count = 0.
- read_o = 0, write_o = 0.
- i_resp = 0, d_resp = 0.
REQ-023 Reset asserted mid-transaction SHALL abort that transaction immediately, with no resp delivered and no counter update; after release the FSM starts from IDLE.
REQ-024 address_o and burst_o SHALL be 0 in IDLE and during reset.

Verification
REQ-025 I-side only: i_read=1 with i_address=0x0000_1000, and the L2 model returns resp_i after 3 cycles with burst_i=0xA5...A5 -> the following occur:
- read_o=1 with address_o=0x1000 from the next cycle.
- i_resp=1 and i_rdata=0xA5...A5 in the resp cycle.
- Return to IDLE.
- i_grant_count=1.
REQ-026 D-side write: d_write=1 with d_address=0x2000 and d_wdata=0x1234...: write_o=1, read_o=0 and burst_o=d_wdata until resp_i, then d_resp=1 for exactly one cycle; i_resp stays 0 throughout.
REQ-027 Simultaneous requests: i_read and d_read are held continuously, with STARVE_LIMIT=4 -> the grant order is D,D,D,D,I,D,D,D,D,I...; starve_cnt clears on each I grant.
REQ-028 Mid-transaction arrival: d_read asserts while SERVE_I is waiting on resp_i -> the following hold:
- address_o stays equal to i_address.
- SERVE_D begins only after the I-side resp plus one IDLE cycle.
REQ-029 Reset and spurious resp: rst=0 is pulsed during SERVE_D -> read_o/write_o drop in the same cycle, no d_resp occurs, and all counters read 0; a spurious resp_i=1 in IDLE -> no upstream resp.
